ula_seq: RTL and testbench
==========================

// Module: ula_seq
// PURPOSE
//  Parametrised sequential ALU; next generation of the 4-bit 8-way result selector.
//  Same 8 ops and opcodes, WIDTH-bit unsigned operands, registered result with status flags.
//  Iterative (multi-cycle) divider; valid/ready handshake on both input and output sides.
//  Accepts one operation at a time.
// PARAMETERS
//  WIDTH  4  operand/result width in bits (>=2)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands/op presented
//  in_ready   out  1      block can accept; =1 iff state==IDLE
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  op         in   3      0 soma,1 sub,2 mult,3 div,4 igual,5 maior,6 menor,7 dif
//  out_valid  out  1      out/resto/flags valid; =1 iff state==DONE
//  out_ready  in   1      consumer takes result
//  out        out  WIDTH  result
//  resto      out  WIDTH  division remainder; 0 for other ops
//  carry      out  1      soma: carry out; sub: borrow (a<b); else 0
//  ovf        out  1      mult: upper WIDTH product bits non-zero; else 0
//  div0       out  1      div with b==0; else 0
//  zero       out  1      out==0
// BEHAVIOUR
//  Reset (rst_n low, async): state IDLE; out, resto, all flags, out_valid = 0;
//   internal counter/regs cleared. Reset mid-division aborts; no result is produced.
//  Accept: in_valid && in_ready at rising edge. a, b, op latched; later input changes ignored.
//  FSM: IDLE -> DONE (ops 0,1,2,4-7, or div with b==0) | DIV (div, b!=0)
//       DIV -> DONE after WIDTH iteration cycles; DONE -> IDLE when out_ready.
//  Latency, accept edge to out_valid high:
//   - ops 0,1,2,4-7 and div-by-zero: 1 cycle.
//   - div with b!=0: WIDTH+1 cycles (WIDTH=4 -> 5).
//  Throughput: at most one op per 2 cycles; in_ready=0 in DIV and DONE.
//  Output hold: in DONE, out/resto/flags stable until the out_ready handshake.
//   out_ready sampled only in DONE; ignored in IDLE/DIV.
//  Arithmetic, all unsigned, modulo 2^WIDTH:
//   - soma: out=(a+b)[WIDTH-1:0].
//   - sub:  out=(a-b)[WIDTH-1:0].
//   - mult: out=(a*b)[WIDTH-1:0].
//   - div:  restoring, one quotient bit per cycle MSB first; out=a/b, resto=a%b.
//   - div0: out={WIDTH{1'b1}}, resto=a, div0=1.
//   - igual/maior/menor/dif: out = zero-extended 1-bit result of a==b / a>b / a<b / a!=b.
//  Flags computed for the accepted op only; flags not listed for that op are 0.
// TESTING
//  WIDTH=4, soma a=9 b=8 -> 1 cycle: out=1, carry=1, zero=0.
//  sub a=3 b=5 -> out=14, carry=1; sub a=5 b=5 -> out=0, zero=1, carry=0.
//  mult a=7 b=3 -> out=5, ovf=1; mult a=3 b=5 -> out=15, ovf=0.
//  div a=13 b=4 -> out_valid exactly 5 cycles after accept; out=3, resto=1; in_ready=0 meanwhile.
//  div a=6 b=0 -> 1 cycle: out=15, resto=6, div0=1.
//  maior a=9 b=4 -> out=1; hold out_ready=0 for 3 cycles -> out/flags stable, in_ready=0.
//   Then out_ready=1 -> IDLE next cycle.
//  Reset pulse 2 cycles into div -> out_valid stays 0, all outputs 0, in_ready=1 after release.
//  Sweep all 8 ops over all a,b for WIDTH=4 and random WIDTH=8 vs reference model.

Source files
------------

// File: rtl/ula_seq.sv
// Sequential unsigned ALU: eight ops, registered result and status flags,
// restoring divider that produces one quotient bit per cycle, valid/ready on both sides.
module ula_seq #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] resto,
   output logic             carry,
   output logic             ovf,
   output logic             div0,
   output logic             zero
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DIV  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [1:0]         state_r;
   logic [CW-1:0]      cnt_r;
   logic [WIDTH-1:0]   quo_r;
   logic [WIDTH-1:0]   rem_r;
   logic [WIDTH-1:0]   dvs_r;
   logic [WIDTH-1:0]   out_r;
   logic [WIDTH-1:0]   resto_r;
   logic               carry_r;
   logic               ovf_r;
   logic               div0_r;
   logic               zero_r;

   logic [WIDTH:0]     sum_s;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   res_out_s;
   logic [WIDTH-1:0]   res_resto_s;
   logic               res_carry_s;
   logic               res_ovf_s;
   logic               res_div0_s;
   logic               start_div_s;
   logic [WIDTH:0]     rem_sh_s;
   logic [WIDTH:0]     rem_nx_s;
   logic               qbit_s;
   logic [WIDTH-1:0]   quo_nx_s;

   assign in_ready  = (state_r == S_IDLE);
   assign out_valid = (state_r == S_DONE);
   assign out       = out_r;
   assign resto     = resto_r;
   assign carry     = carry_r;
   assign ovf       = ovf_r;
   assign div0      = div0_r;
   assign zero      = zero_r;

   // Single-cycle results for every op; only the b==0 case of div is taken from here.
   always_comb begin
      sum_s       = {1'b0, a} + {1'b0, b};
      prod_s      = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      res_out_s   = {WIDTH{1'b0}};
      res_resto_s = {WIDTH{1'b0}};
      res_carry_s = 1'b0;
      res_ovf_s   = 1'b0;
      res_div0_s  = 1'b0;
      start_div_s = (op == 3'd3) && (b != {WIDTH{1'b0}});
      case (op)
         3'd0: begin
            res_out_s   = sum_s[WIDTH-1:0];
            res_carry_s = sum_s[WIDTH];
         end
         3'd1: begin
            res_out_s   = a - b;
            res_carry_s = (a < b);
         end
         3'd2: begin
            res_out_s = prod_s[WIDTH-1:0];
            res_ovf_s = |prod_s[2*WIDTH-1:WIDTH];
         end
         3'd3: begin
            res_out_s   = {WIDTH{1'b1}};
            res_resto_s = a;
            res_div0_s  = 1'b1;
         end
         3'd4: res_out_s = {{(WIDTH-1){1'b0}}, (a == b)};
         3'd5: res_out_s = {{(WIDTH-1){1'b0}}, (a > b)};
         3'd6: res_out_s = {{(WIDTH-1){1'b0}}, (a < b)};
         3'd7: res_out_s = {{(WIDTH-1){1'b0}}, (a != b)};
         default: res_out_s = {WIDTH{1'b0}};
      endcase
   end

   // One restoring-division step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      rem_sh_s = {rem_r, quo_r[WIDTH-1]};
      if (rem_sh_s >= {1'b0, dvs_r}) begin
         rem_nx_s = rem_sh_s - {1'b0, dvs_r};
         qbit_s   = 1'b1;
      end else begin
         rem_nx_s = rem_sh_s;
         qbit_s   = 1'b0;
      end
      quo_nx_s = {quo_r[WIDTH-2:0], qbit_s};
   end

   // Control FSM plus result/flag registers, held stable throughout DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
         cnt_r   <= {CW{1'b0}};
         quo_r   <= {WIDTH{1'b0}};
         rem_r   <= {WIDTH{1'b0}};
         dvs_r   <= {WIDTH{1'b0}};
         out_r   <= {WIDTH{1'b0}};
         resto_r <= {WIDTH{1'b0}};
         carry_r <= 1'b0;
         ovf_r   <= 1'b0;
         div0_r  <= 1'b0;
         zero_r  <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (in_valid) begin
                  if (start_div_s) begin
                     state_r <= S_DIV;
                     quo_r   <= a;
                     dvs_r   <= b;
                     rem_r   <= {WIDTH{1'b0}};
                     cnt_r   <= {CW{1'b0}};
                  end else begin
                     state_r <= S_DONE;
                     out_r   <= res_out_s;
                     resto_r <= res_resto_s;
                     carry_r <= res_carry_s;
                     ovf_r   <= res_ovf_s;
                     div0_r  <= res_div0_s;
                     zero_r  <= (res_out_s == {WIDTH{1'b0}});
                  end
               end
            end
            S_DIV: begin
               quo_r <= quo_nx_s;
               rem_r <= rem_nx_s[WIDTH-1:0];
               cnt_r <= cnt_r + CW'(1);
               // The last step writes the result directly so DONE follows after WIDTH cycles.
               if (cnt_r == CNT_LAST) begin
                  state_r <= S_DONE;
                  out_r   <= quo_nx_s;
                  resto_r <= rem_nx_s[WIDTH-1:0];
                  carry_r <= 1'b0;
                  ovf_r   <= 1'b0;
                  div0_r  <= 1'b0;
                  zero_r  <= (quo_nx_s == {WIDTH{1'b0}});
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state_r <= S_IDLE;
               end
            end
            default: state_r <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ula_seq.sv
// Directed and sweep bench for ula_seq: WIDTH=4 and WIDTH=8 instances checked
// against hand-computed vectors and an arithmetic reference model.
module tb_ula_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       iv4, ir4, ov4, or4, c4, v4, d4, z4;
   logic [3:0] a4, b4, o4, r4;
   logic [2:0] op4;
   logic       iv8, ir8, ov8, or8, c8, v8, d8, z8;
   logic [7:0] a8, b8, o8, r8;
   logic [2:0] op8;

   ula_seq #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .op(op4),
      .out_valid(ov4), .out_ready(or4), .out(o4), .resto(r4),
      .carry(c4), .ovf(v4), .div0(d4), .zero(z4));

   ula_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .op(op8),
      .out_valid(ov8), .out_ready(or8), .out(o8), .resto(r8),
      .carry(c8), .ovf(v8), .div0(d8), .zero(z8));

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      logic [2:0] op;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] eo;
      logic [3:0] er;
      logic [3:0] ef;   // {carry, ovf, div0, zero}
      int         lat;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [19:0] model(input int w, input logic [7:0] x, input logic [7:0] y,
                                         input logic [2:0] o);
      logic [15:0] m, t;
      logic [7:0]  q, r;
      logic        c, v, d;
      m = (16'd1 << w) - 16'd1;
      q = 8'd0; r = 8'd0; c = 1'b0; v = 1'b0; d = 1'b0; t = 16'd0;
      case (o)
         3'd0: begin t = {8'd0, x} + {8'd0, y}; q = t[7:0] & m[7:0]; c = (t >> w) != 16'd0; end
         3'd1: begin t = {8'd0, x} - {8'd0, y}; q = t[7:0] & m[7:0]; c = (x < y); end
         3'd2: begin t = {8'd0, x} * {8'd0, y}; q = t[7:0] & m[7:0]; v = (t >> w) != 16'd0; end
         3'd3: begin
            if (y == 8'd0) begin q = m[7:0]; r = x; d = 1'b1; end
            else begin q = x / y; r = x % y; end
         end
         3'd4: q = {7'd0, x == y};
         3'd5: q = {7'd0, x > y};
         3'd6: q = {7'd0, x < y};
         default: q = {7'd0, x != y};
      endcase
      return {q, r, c, v, d, (q == 8'd0)};
   endfunction

   function automatic logic [19:0] snap(input int w);
      if (w == 4) return {4'h0, o4, 4'h0, r4, c4, v4, d4, z4};
      else return {o8, r8, c8, v8, d8, z8};
   endfunction

   function automatic logic vld(input int w);
      return (w == 4) ? ov4 : ov8;
   endfunction

   function automatic logic rdy(input int w);
      return (w == 4) ? ir4 : ir8;
   endfunction

   task automatic drive(input int w, input logic v, input logic [7:0] x, input logic [7:0] y,
                        input logic [2:0] o);
      if (w == 4) begin iv4 = v; a4 = x[3:0]; b4 = y[3:0]; op4 = o; end
      else begin iv8 = v; a8 = x; b8 = y; op8 = o; end
   endtask

   task automatic set_ordy(input int w, input logic v);
      if (w == 4) or4 = v;
      else or8 = v;
   endtask

   // Full transaction: accept, measure latency, compare result, hand the result off.
   task automatic run_op(input int w, input logic [7:0] x, input logic [7:0] y, input logic [2:0] o,
                         input logic [19:0] exp, input int exp_lat, input string tag);
      int lat;
      @(negedge clk);
      check({tag, " in_ready idle"}, 32'(rdy(w)), 32'd1);
      drive(w, 1'b1, x, y, o);
      @(posedge clk); #1;
      drive(w, 1'b0, ~x, ~y, o + 3'd1);
      lat = 1;
      if (exp_lat > 1) check({tag, " in_ready busy"}, 32'(rdy(w)), 32'd0);
      while (!vld(w) && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " result"}, 32'(snap(w)), 32'(exp));
      @(negedge clk);
      set_ordy(w, 1'b1);
      @(posedge clk); #1;
      set_ordy(w, 1'b0);
      check({tag, " back to idle"}, {30'd0, vld(w), rdy(w)}, 32'd1);
   endtask

   initial begin
      logic [19:0] held;
      int lat;
      iv4 = 1'b0; or4 = 1'b0; a4 = 4'd0; b4 = 4'd0; op4 = 3'd0;
      iv8 = 1'b0; or8 = 1'b0; a8 = 8'd0; b8 = 8'd0; op8 = 3'd0;

      vecs = '{
         '{3'd0, 4'd9,  4'd8, 4'd1,  4'd0, 4'b1000, 1},
         '{3'd1, 4'd3,  4'd5, 4'd14, 4'd0, 4'b1000, 1},
         '{3'd1, 4'd5,  4'd5, 4'd0,  4'd0, 4'b0001, 1},
         '{3'd2, 4'd7,  4'd3, 4'd5,  4'd0, 4'b0100, 1},
         '{3'd2, 4'd3,  4'd5, 4'd15, 4'd0, 4'b0000, 1},
         '{3'd3, 4'd13, 4'd4, 4'd3,  4'd1, 4'b0000, 5},
         '{3'd3, 4'd6,  4'd0, 4'd15, 4'd6, 4'b0010, 1},
         '{3'd5, 4'd9,  4'd4, 4'd1,  4'd0, 4'b0000, 1},
         '{3'd4, 4'd5,  4'd5, 4'd1,  4'd0, 4'b0000, 1},
         '{3'd6, 4'd2,  4'd9, 4'd1,  4'd0, 4'b0000, 1},
         '{3'd7, 4'd7,  4'd7, 4'd0,  4'd0, 4'b0001, 1},
         '{3'd0, 4'd0,  4'd0, 4'd0,  4'd0, 4'b0001, 1},
         '{3'd3, 4'd15, 4'd1, 4'd15, 4'd0, 4'b0000, 5},
         '{3'd3, 4'd3,  4'd7, 4'd0,  4'd3, 4'b0001, 5},
         '{3'd2, 4'd15, 4'd15, 4'd1, 4'd0, 4'b0100, 1},
         '{3'd5, 4'd4,  4'd9, 4'd0,  4'd0, 4'b0001, 1}
      };

      repeat (2) @(posedge clk);
      #1;
      check("reset w4 outputs", 32'(snap(4)), 32'd0);
      check("reset w8 outputs", 32'(snap(8)), 32'd0);
      check("reset w4 handshake", {30'd0, ov4, ir4}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         run_op(4, {4'd0, vecs[i].a}, {4'd0, vecs[i].b}, vecs[i].op,
                {4'd0, vecs[i].eo, 4'd0, vecs[i].er, vecs[i].ef}, vecs[i].lat,
                $sformatf("vec%0d", i));
      end

      // maior result held while the consumer stalls; new inputs must be ignored
      @(negedge clk);
      drive(4, 1'b1, 8'd9, 8'd4, 3'd5);
      @(posedge clk); #1;
      drive(4, 1'b1, 8'd1, 8'd2, 3'd0);
      held = snap(4);
      check("hold initial", 32'(held), 32'h01000);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check($sformatf("hold stable %0d", k), 32'(snap(4)), 32'(held));
         check($sformatf("hold handshake %0d", k), {30'd0, ov4, ir4}, 32'd2);
      end
      @(negedge clk);
      or4 = 1'b1;
      iv4 = 1'b0;
      @(posedge clk); #1;
      or4 = 1'b0;
      check("hold release", {30'd0, ov4, ir4}, 32'd1);

      // out_ready held high through a division must not end it early
      @(negedge clk);
      or4 = 1'b1;
      drive(4, 1'b1, 8'd14, 8'd3, 3'd3);
      @(posedge clk); #1;
      drive(4, 1'b0, 8'd0, 8'd0, 3'd0);
      lat = 1;
      while (!ov4 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check("div ordy latency", 32'(lat), 32'd5);
      check("div ordy result", 32'(snap(4)), 32'h04020);
      @(posedge clk); #1;
      or4 = 1'b0;
      check("div ordy idle", {30'd0, ov4, ir4}, 32'd1);

      // reset two cycles into a division aborts it
      @(negedge clk);
      drive(4, 1'b1, 8'd13, 8'd4, 3'd3);
      @(posedge clk); #1;
      drive(4, 1'b0, 8'd0, 8'd0, 3'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      check("abort outputs", 32'(snap(4)), 32'd0);
      check("abort handshake", {30'd0, ov4, ir4}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("abort no result", {30'd0, ov4, ir4}, 32'd1);
      check("abort outputs after", 32'(snap(4)), 32'd0);

      for (int o = 0; o < 8; o++) begin
         for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
               run_op(4, 8'(x), 8'(y), 3'(o), model(4, 8'(x), 8'(y), 3'(o)),
                      (o == 3 && y != 0) ? 5 : 1, $sformatf("w4 op%0d a%0d b%0d", o, x, y));
            end
         end
      end

      run_op(8, 8'd255, 8'd1, 3'd3, {8'd255, 8'd0, 4'b0000}, 9, "w8 div 255/1");
      run_op(8, 8'd200, 8'd100, 3'd0, {8'd44, 8'd0, 4'b1000}, 1, "w8 soma carry");
      for (int i = 0; i < 300; i++) begin
         logic [7:0] x, y;
         logic [2:0] o;
         x = 8'($urandom_range(0, 255));
         y = 8'($urandom_range(0, 255));
         if (i % 16 == 0) y = 8'd0;
         o = 3'($urandom_range(0, 7));
         run_op(8, x, y, o, model(8, x, y, o), (o == 3'd3 && y != 8'd0) ? 9 : 1,
                $sformatf("w8 op%0d a%0d b%0d", o, x, y));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
